spi_tx_engine: RTL and testbench
================================

Name: spi_tx_engine

Overview:
- Parametrised SPI master transmit engine. Generalises the single-byte, externally-clocked shift register into a self-timed transfer engine.
- Adds configurable word width, internal SCLK divider, all four SPI modes, bit order, chip-select framing and a valid/ready input handshake.
- Sits between the command/FIFO logic and the SPI pins; drives SCLK, MOSI and CS_n for one slave.

Parameters:
- DATA_W, 8, bits per word; legal range 2 or more.
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1 or more.
- MSB_FIRST, 1, 1 = bit DATA_W-1 shifted first, 0 = bit 0 shifted first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_tx_valid  in  1  word available.
- o_tx_ready  out  1  engine can accept a word.
- i_tx_data  in  DATA_W  word to send, sampled on accept.
- i_cpol  in  1  SCLK idle level, sampled on accept.
- i_cpha  in  1  SPI phase, sampled on accept.
- o_sclk  out  1  SPI clock.
- o_mosi  out  1  SPI data out.
- o_cs_n  out  1  chip select, active low.
- o_busy  out  1  transfer in progress (state is not IDLE).
- o_done  out  1  one-cycle pulse at end of each word.

Behaviour:
- Reset values (asynchronous): o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_done=0, o_tx_ready=0. o_tx_ready rises on the first clk after reset_n deasserts. State = IDLE.
- States: IDLE, LEAD, SHIFT, TRAIL. All outputs are registered, except o_tx_ready, which is decoded from state.
- Accept rule: a word is accepted when i_tx_valid and o_tx_ready are both high on a clk edge. i_tx_data, i_cpol and i_cpha are latched at that edge; later changes to them are ignored until the next accept.
- IDLE:
  - o_tx_ready=1, o_cs_n=1, o_mosi=0.
  - o_sclk tracks i_cpol, registered, so the idle level is correct before CS falls.
  - On accept, go to LEAD on the next cycle.
- Half-period counter: counts 0..CLK_DIV-1, cleared on every state entry. "End of a half-period" means the cycle in which the count reaches CLK_DIV-1.
- Timeline:
  - Half-periods numbered hp0..hp(2*DATA_W): hp0 = LEAD, hp1..hp(2*DATA_W-1) = SHIFT, hp(2*DATA_W) = TRAIL.
  - Edge k (k = 1..2*DATA_W) occurs at the end of hp(k-1).
  - o_sclk toggles at every edge. After edge 2*DATA_W, o_sclk is back at CPOL.
  - CS_n is low for exactly (2*DATA_W+1)*CLK_DIV cycles.
- Bit order: bit j (j = 0..DATA_W-1) is the j-th bit sent, per MSB_FIRST.
- CPHA=0:
  - Bit 0 is on o_mosi from the first LEAD cycle.
  - Bit j is driven at edge 2j (j ≥ 1); the slave samples at odd edges.
- CPHA=1:
  - o_mosi holds 0 through LEAD.
  - Bit j is driven at edge 2j+1; the slave samples at even edges.
- o_mosi holds the last bit through TRAIL and returns to 0 in IDLE.
- TRAIL end: o_done=1 for exactly one cycle, o_cs_n=1 in the same cycle, state returns to IDLE.
  - Minimum CS_n high time between words is 1 cycle, in the non-burst build.
- Counters: shift counter is clog2(2*DATA_W+1) bits wide; no wrap occurs inside a word.
- Reset mid-transfer: everything returns to reset values immediately. The partial word is discarded and no o_done is generated.
- i_tx_valid while busy: held off (o_tx_ready=0). No data is lost; the upstream block holds the word.

Optional Feature:
- Macro SPI_TX_BURST_EN.
- When defined:
  - o_tx_ready is also high during TRAIL.
  - An accept in TRAIL latches new data only; CPOL/CPHA are retained from the current word.
  - CS_n stays low, and TRAIL doubles as the LEAD of the next word:
    - CPHA=0: new bit 0 appears on o_mosi the cycle after the accept.
    - At TRAIL end, o_done pulses and state goes directly to SHIFT (edge 1).
  - Back-to-back words therefore run with no CS_n gap and a uniform SCLK.
- When undefined: o_tx_ready is high only in IDLE, and each word is framed by its own CS_n.

Test Plan:
- DATA_W=8, CLK_DIV=2, MSB_FIRST=1, mode 0, send 0xA5:
  - CS_n low 34 cycles.
  - MOSI sampled on SCLK rising edges = 1,0,1,0,0,1,0,1.
  - One o_done pulse coincident with CS_n rising.
- Same setup, mode 3 (cpol=1, cpha=1), send 0x3C:
  - SCLK idles high and starts high.
  - MOSI changes on falling edges; sampled on rising edges = 0,0,1,1,1,1,0,0.
  - SCLK ends high.
- MSB_FIRST=0, CLK_DIV=1, mode 1, send 0x01:
  - First sampled bit = 1, remaining seven = 0.
  - SCLK period 2 cycles; CS_n low 17 cycles.
- Mid-transfer reset:
  - Assert reset_n=0 after edge 5 of 0xFF.
  - Outputs go to reset values within the same cycle; no o_done.
  - The next accepted 0x81 transmits correctly.
- i_cpha toggled and i_tx_data changed while busy:
  - Transmitted word and mode are unchanged.
  - o_tx_ready stays 0 until IDLE (non-burst build).
- With SPI_TX_BURST_EN, i_tx_valid held high with 0x12 then 0x34:
  - CS_n low continuously for 2*(16*2)+2 cycles.
  - Two o_done pulses; 16 SCLK cycles total.
  - Slave receives 0x12, 0x34.

Source files
------------

// File: rtl/spi_tx_engine.sv
// rtl/spi_tx_engine.sv - self-timed SPI master transmit engine with CS_n framing and valid/ready input
// Optional SPI_TX_BURST_EN: accept the next word during TRAIL so CS_n stays low between words.
module spi_tx_engine #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_cpol,
  input  logic              i_cpha,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HP_LAST    = HW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_FINAL = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t            state;
  logic [HW-1:0]     hp_cnt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] sr;
  logic              cpha_q;
  logic              started;
  logic              hp_end;
  logic              accept;
`ifdef SPI_TX_BURST_EN
  logic              pending;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
  endfunction

`ifdef SPI_TX_BURST_EN
  assign o_tx_ready = started && (state == IDLE || (state == TRAIL && !pending));
`else
  assign o_tx_ready = started && (state == IDLE);
`endif
  assign accept = i_tx_valid && o_tx_ready;
  assign hp_end = (hp_cnt == HP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hp_cnt   <= '0;
      edge_cnt <= '0;
      sr       <= '0;
      cpha_q   <= 1'b0;
      started  <= 1'b0;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_cs_n   <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
`ifdef SPI_TX_BURST_EN
      pending  <= 1'b0;
`endif
    end else begin
      started <= 1'b1;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          o_sclk <= i_cpol;
          o_mosi <= 1'b0;
          o_cs_n <= 1'b1;
          o_busy <= 1'b0;
          if (accept) begin
            state    <= LEAD;
            o_busy   <= 1'b1;
            o_cs_n   <= 1'b0;
            cpha_q   <= i_cpha;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            if (!i_cpha) begin
              o_mosi <= first_bit(i_tx_data);
              sr     <= drop_bit(i_tx_data);
            end else begin
              sr <= i_tx_data;
            end
          end
        end
        LEAD: begin
          if (hp_end) begin
            o_sclk   <= ~o_sclk;
            edge_cnt <= EW'(1);
            hp_cnt   <= '0;
            state    <= SHIFT;
            if (cpha_q) begin
              o_mosi <= first_bit(sr);
              sr     <= drop_bit(sr);
            end
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (hp_end) begin
            o_sclk   <= ~o_sclk;
            edge_cnt <= edge_cnt + 1'b1;
            hp_cnt   <= '0;
            // Upcoming edge number is edge_cnt+1: CPHA=0 drives on even edges, CPHA=1 on odd ones.
            if ((edge_cnt[0] ^ cpha_q) && edge_cnt != EDGE_FINAL) begin
              o_mosi <= first_bit(sr);
              sr     <= drop_bit(sr);
            end
            if (edge_cnt == EDGE_FINAL) state <= TRAIL;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        TRAIL: begin
`ifdef SPI_TX_BURST_EN
          if (accept) begin
            pending <= 1'b1;
            if (!cpha_q) begin
              o_mosi <= first_bit(i_tx_data);
              sr     <= drop_bit(i_tx_data);
            end else begin
              sr <= i_tx_data;
            end
          end
`endif
          if (hp_end) begin
            o_done <= 1'b1;
            hp_cnt <= '0;
`ifdef SPI_TX_BURST_EN
            if (pending || accept) begin
              // TRAIL served as the next word's LEAD: its end is edge 1 of that word.
              state    <= SHIFT;
              pending  <= 1'b0;
              o_sclk   <= ~o_sclk;
              edge_cnt <= EW'(1);
              if (cpha_q) begin
                o_mosi <= first_bit(accept ? i_tx_data : sr);
                sr     <= drop_bit(accept ? i_tx_data : sr);
              end
            end else begin
              state  <= IDLE;
              o_cs_n <= 1'b1;
              o_busy <= 1'b0;
              o_mosi <= 1'b0;
            end
`else
            state  <= IDLE;
            o_cs_n <= 1'b1;
            o_busy <= 1'b0;
            o_mosi <= 1'b0;
`endif
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// tb/tb_spi_tx_engine.sv - directed checks of spi_tx_engine in two parameter sets.
module tb_spi_tx_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       cpol;
  logic       cpha;
  logic       sel;

  logic rdy0, sclk0, mosi0, cs0, busy0, done0;
  logic rdy1, sclk1, mosi1, cs1, busy1, done1;
  logic v0, v1;
  logic s_rdy, s_sclk, s_mosi, s_cs_n, s_busy, s_done;

  int vectors = 0;
  int miscompares = 0;

  int         w_cs_low, w_edges, w_dones, w_done_bad, w_mosi_bad, w_ready_bad, w_busy_bad;
  logic [15:0] w_rx;
  logic       w_sclk_first, w_sclk_last, w_timeout;
  logic [7:0] w_words [2];

  always #5 clk = ~clk;

  assign v0 = tx_valid & ~sel;
  assign v1 = tx_valid & sel;
  assign s_rdy  = sel ? rdy1  : rdy0;
  assign s_sclk = sel ? sclk1 : sclk0;
  assign s_mosi = sel ? mosi1 : mosi0;
  assign s_cs_n = sel ? cs1   : cs0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;

  spi_tx_engine #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_n(reset_n), .i_tx_valid(v0), .o_tx_ready(rdy0), .i_tx_data(tx_data),
    .i_cpol(cpol), .i_cpha(cpha), .o_sclk(sclk0), .o_mosi(mosi0), .o_cs_n(cs0),
    .o_busy(busy0), .o_done(done0)
  );

  spi_tx_engine #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .i_tx_valid(v1), .o_tx_ready(rdy1), .i_tx_data(tx_data),
    .i_cpol(cpol), .i_cpha(cpha), .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs1),
    .o_busy(busy1), .o_done(done1)
  );

  task automatic start_word(input logic s, input logic [7:0] d, input logic cp, input logic ch,
                            output logic ok);
    ok = 1'b0;
    sel = s;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    tx_data = d;
    cpol = cp;
    cpha = ch;
    @(negedge clk);
    tx_valid = 1'b1;
  endtask

  // Slave-side observer: samples every cycle on the falling clk edge until CS_n rises again.
  task automatic watch(input logic cp, input logic ch, input int nwords, input int perturb_at);
    logic prev_s, prev_m, prev_c, seen, lead, acc_next, fin;
    int acc;
    w_cs_low = 0; w_edges = 0; w_dones = 0; w_done_bad = 0; w_mosi_bad = 0;
    w_ready_bad = 0; w_busy_bad = 0; w_rx = '0; w_sclk_first = 1'bx; w_sclk_last = 1'bx;
    seen = 1'b0; fin = 1'b0; acc = 0;
    prev_s = s_sclk; prev_m = s_mosi; prev_c = s_cs_n;
    acc_next = tx_valid && s_rdy;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (acc_next) begin
        acc++;
        if (acc < nwords) tx_data = w_words[acc];
        else tx_valid = 1'b0;
      end
      lead = (s_sclk != cp);
      if (s_done) begin
        w_dones++;
        if (s_cs_n !== 1'b1) w_done_bad++;
      end
      if (!s_cs_n) begin
        w_cs_low++;
        if (!seen) w_sclk_first = s_sclk;
        seen = 1'b1;
        if (!s_busy) w_busy_bad++;
        if (s_sclk !== prev_s) begin
          w_edges++;
          if (lead ^ ch) w_rx = {w_rx[14:0], s_mosi};
        end
        if (!prev_c && s_mosi !== prev_m && !(s_sclk !== prev_s && lead == ch)) w_mosi_bad++;
`ifndef SPI_TX_BURST_EN
        if (perturb_at != 0 && s_rdy) w_ready_bad++;
`endif
        if (w_cs_low == perturb_at) begin
          tx_data = ~tx_data;
          cpha = ~cpha;
`ifndef SPI_TX_BURST_EN
          tx_valid = 1'b1;
`endif
        end
      end else if (seen) begin
        w_sclk_last = s_sclk;
        fin = 1'b1;
        tx_valid = 1'b0;
      end
      acc_next = tx_valid && s_rdy;
      prev_s = s_sclk; prev_m = s_mosi; prev_c = s_cs_n;
    end
    w_timeout = !fin;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0; sel = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++; if ({sclk0, mosi0, cs0, busy0, done0} !== 5'b00100) begin
      miscompares++; $display("FAIL reset_outputs got %b want 00100", {sclk0, mosi0, cs0, busy0, done0}); end
    vectors++; if ({rdy0, rdy1} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready got %b want 00", {rdy0, rdy1}); end
    reset_n = 1'b1;
    #1;
    vectors++; if (rdy0 !== 1'b0) begin
      miscompares++; $display("FAIL ready_before_clk got %b want 0", rdy0); end
    @(posedge clk); #1;
    vectors++; if ({rdy0, rdy1} !== 2'b11) begin
      miscompares++; $display("FAIL ready_after_clk got %b want 11", {rdy0, rdy1}); end
  endtask

  task automatic test_mode0();
    logic ok;
    start_word(1'b0, 8'hA5, 1'b0, 1'b0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mode0_ready got %b want 1", ok); end
    watch(1'b0, 1'b0, 1, 0);
    vectors++; if (w_timeout !== 1'b0) begin miscompares++; $display("FAIL mode0_timeout got %b want 0", w_timeout); end
    vectors++; if (w_rx[7:0] !== 8'hA5) begin miscompares++; $display("FAIL mode0_rx got %h want a5", w_rx[7:0]); end
    vectors++; if (w_cs_low !== 34) begin miscompares++; $display("FAIL mode0_cs_low got %0d want 34", w_cs_low); end
    vectors++; if (w_edges !== 16) begin miscompares++; $display("FAIL mode0_edges got %0d want 16", w_edges); end
    vectors++; if (w_dones !== 1 || w_done_bad !== 0) begin
      miscompares++; $display("FAIL mode0_done got %0d/%0d want 1/0", w_dones, w_done_bad); end
    vectors++; if (w_mosi_bad !== 0) begin miscompares++; $display("FAIL mode0_mosi_timing got %0d want 0", w_mosi_bad); end
    vectors++; if (w_busy_bad !== 0) begin miscompares++; $display("FAIL mode0_busy got %0d want 0", w_busy_bad); end
    vectors++; if (w_sclk_last !== 1'b0) begin miscompares++; $display("FAIL mode0_sclk_end got %b want 0", w_sclk_last); end
  endtask

  task automatic test_mode3();
    logic ok;
    start_word(1'b0, 8'h3C, 1'b1, 1'b1, ok);
    vectors++; if (sclk0 !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_idle got %b want 1", sclk0); end
    watch(1'b1, 1'b1, 1, 0);
    vectors++; if (w_rx[7:0] !== 8'h3C) begin miscompares++; $display("FAIL mode3_rx got %h want 3c", w_rx[7:0]); end
    vectors++; if (w_sclk_first !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_start got %b want 1", w_sclk_first); end
    vectors++; if (w_sclk_last !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_end got %b want 1", w_sclk_last); end
    vectors++; if (w_mosi_bad !== 0) begin miscompares++; $display("FAIL mode3_mosi_timing got %0d want 0", w_mosi_bad); end
    vectors++; if (w_cs_low !== 34) begin miscompares++; $display("FAIL mode3_cs_low got %0d want 34", w_cs_low); end
  endtask

  task automatic test_lsb_div1();
    logic ok;
    start_word(1'b1, 8'h01, 1'b0, 1'b1, ok);
    watch(1'b0, 1'b1, 1, 0);
    vectors++; if (w_rx[7:0] !== 8'h80) begin miscompares++; $display("FAIL lsb_rx_order got %h want 80", w_rx[7:0]); end
    vectors++; if (w_cs_low !== 17) begin miscompares++; $display("FAIL lsb_cs_low got %0d want 17", w_cs_low); end
    vectors++; if (w_edges !== 16) begin miscompares++; $display("FAIL lsb_edges got %0d want 16", w_edges); end
    vectors++; if (w_dones !== 1) begin miscompares++; $display("FAIL lsb_done got %0d want 1", w_dones); end
    vectors++; if (w_mosi_bad !== 0) begin miscompares++; $display("FAIL lsb_mosi_timing got %0d want 0", w_mosi_bad); end
    sel = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic ok, prev_s;
    int edges, dones;
    start_word(1'b0, 8'hFF, 1'b0, 1'b0, ok);
    edges = 0; dones = 0; prev_s = sclk0;
    for (int i = 0; i < 100 && edges < 5; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (sclk0 !== prev_s) edges++;
      prev_s = sclk0;
    end
    vectors++; if (edges !== 5) begin miscompares++; $display("FAIL midrst_edges got %0d want 5", edges); end
    reset_n = 1'b0;
    #1;
    vectors++; if ({sclk0, mosi0, cs0, busy0, done0, rdy0} !== 6'b001000) begin
      miscompares++; $display("FAIL midrst_outputs got %b want 001000", {sclk0, mosi0, cs0, busy0, done0, rdy0}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    start_word(1'b0, 8'h81, 1'b0, 1'b0, ok);
    watch(1'b0, 1'b0, 1, 0);
    vectors++; if (w_rx[7:0] !== 8'h81) begin miscompares++; $display("FAIL midrst_next_rx got %h want 81", w_rx[7:0]); end
    vectors++; if (w_dones !== 1 || w_cs_low !== 34) begin
      miscompares++; $display("FAIL midrst_next_frame got %0d/%0d want 1/34", w_dones, w_cs_low); end
  endtask

  task automatic test_busy_changes();
    logic ok;
    start_word(1'b0, 8'h5A, 1'b0, 1'b0, ok);
    watch(1'b0, 1'b0, 1, 6);
    vectors++; if (w_rx[7:0] !== 8'h5A) begin miscompares++; $display("FAIL busy_rx got %h want 5a", w_rx[7:0]); end
    vectors++; if (w_mosi_bad !== 0) begin miscompares++; $display("FAIL busy_mode_kept got %0d want 0", w_mosi_bad); end
    vectors++; if (w_ready_bad !== 0) begin miscompares++; $display("FAIL busy_ready got %0d want 0", w_ready_bad); end
    vectors++; if (w_cs_low !== 34) begin miscompares++; $display("FAIL busy_cs_low got %0d want 34", w_cs_low); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    vectors++; if (cs0 !== 1'b1) begin miscompares++; $display("FAIL busy_no_extra_word got %b want 1", cs0); end
  endtask

`ifdef SPI_TX_BURST_EN
  task automatic test_back_to_back();
    logic ok;
    w_words[0] = 8'h12;
    w_words[1] = 8'h34;
    start_word(1'b0, 8'h12, 1'b0, 1'b0, ok);
    watch(1'b0, 1'b0, 2, 0);
    vectors++; if (w_cs_low !== 66) begin miscompares++; $display("FAIL burst_cs_low got %0d want 66", w_cs_low); end
    vectors++; if (w_dones !== 2) begin miscompares++; $display("FAIL burst_dones got %0d want 2", w_dones); end
    vectors++; if (w_edges !== 32) begin miscompares++; $display("FAIL burst_edges got %0d want 32", w_edges); end
    vectors++; if (w_rx !== 16'h1234) begin miscompares++; $display("FAIL burst_rx got %h want 1234", w_rx); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got stuck want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_lsb_div1();
    test_mid_reset();
    test_busy_changes();
`ifdef SPI_TX_BURST_EN
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
